simplez_uart_tx: RTL and testbench
==================================

SIMPLEZ_UART_TX -- requirements
Module: simplez_uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 104, clock cycles per serial bit (12 MHz / 115200); legal range 2..1023.
REQ-002 Parameter ADDR_DATA, default 9'o101, bus address of the transmit data register.
REQ-003 Parameter ADDR_STAT, default 9'o102, bus address of the status register.
REQ-004 Port clk, input, 1, system clock; all state updates on the falling edge, matching the CPU.
REQ-005 Port rstn, input, 1, reset, synchronous, active-low.
REQ-006 Port addr, input, 9, CPU address register (RA) value.
REQ-007 Port wr, input, 1, CPU write strobe (esc).
REQ-008 Port rd, input, 1, CPU read strobe (lec).
REQ-009 Port data_in, input, 12, CPU data bus; only bits [7:0] are used.
REQ-010 Port data_out, output, 12, read data returned to the CPU.
REQ-011 Port tx, output, 1, serial line, 8N1, idle high.

Function
REQ-012 The block SHALL be a bus responder: a falling edge with wr=1 and addr==ADDR_DATA SHALL be one push of data_in[7:0] into a 4-entry FIFO.
REQ-013 A push while the FIFO holds 4 entries and no pop occurs in the same edge SHALL be dropped and SHALL set the sticky ovf flag.
REQ-014 A simultaneous push and pop on a full FIFO SHALL both be accepted, so the count stays 4 and ovf stays unchanged.
REQ-015 data_out SHALL be combinational: when rd=1 and addr==ADDR_STAT it SHALL be {9'b0, ovf, busy, ready}; otherwise it SHALL be 12'd0. A read of ADDR_DATA returns 0.
REQ-016 ready SHALL be 1 when FIFO count is below 4.
REQ-017 busy SHALL be 1 when the FSM is not IDLE or the FIFO is non-empty.
REQ-018 A falling edge with rd=1 and addr==ADDR_STAT SHALL clear ovf, unless a dropped push occurs on the same edge; in that case ovf stays 1.
REQ-019 The transmit FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-020 In IDLE tx SHALL be 1. When the FIFO is non-empty, the FSM SHALL pop the head into an 8-bit shifter, load the baud counter with BAUD_DIV-1, and go to START on the same edge.
REQ-021 The baud counter SHALL decrement every cycle; each bit period SHALL end on the edge where it equals 0, after which it reloads BAUD_DIV-1.
REQ-022 In START tx SHALL be 0 for one bit period, then the FSM goes to DATA with bit index 0.
REQ-023 In DATA tx SHALL be shifter[0], LSB first. The shifter right-shifts at each period end; after bit index 7 the FSM goes to STOP.
REQ-024 In STOP tx SHALL be 1 for one bit period.
REQ-025 At the end of STOP, a non-empty FIFO SHALL pop and go directly to START, with no idle gap; an empty FIFO SHALL go to IDLE.
REQ-026 Frame length SHALL be exactly 10*BAUD_DIV cycles from IDLE exit to STOP end.
REQ-027 The first start bit SHALL appear on tx one cycle after the push edge into an empty, idle block.
REQ-028 FIFO read and write pointers SHALL be 2-bit and wrap modulo 4. Count SHALL be 3-bit, range 0..4.
REQ-029 Accesses to any other address SHALL have no effect on state.

Reset
REQ-030 On a falling edge with rstn=0 the block SHALL set: FSM to IDLE, tx to 1, FIFO to empty (pointers 0, count 0), ovf to 0, shifter and baud counter to 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 after that edge and no partial byte SHALL resume.
REQ-032 With rstn=0 and rd=1 at ADDR_STAT, data_out SHALL reflect the reset state from the next cycle onward: 12'h001.

Structure
REQ-033 Package simplez_pkg SHALL hold DATAW=12, ADDRW=9, the peripheral address constants, and the tx FSM state encoding.
REQ-034 The FIFO SHALL be a sub-module simplez_fifo (depth 4, width 8) with push, pop, full, empty and count ports.
REQ-035 The block SHALL be instantiated beside the memory and share the CPU's RA/esc/lec/busD nets.

Verification
REQ-036 BAUD_DIV=4, write 12'h055 to 9'o101 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; status goes 0x003 during the frame, then 0x001.
REQ-037 Five back-to-back writes 0x41..0x45 while idle -> first pops immediately and four are queued, no ovf; a sixth write at once -> dropped, status bit2=1; next status read returns 0x006 then ovf clears.
REQ-038 Two queued bytes -> second start bit immediately follows first stop bit (no extra high cycle); total 80 cycles.
REQ-039 rstn=0 at cycle 15 of a frame -> tx=1 next edge, FIFO empty, status 0x001, no further transitions.
REQ-040 Full FIFO with push on the pop edge (end of STOP) -> byte accepted, count stays 4, ovf stays 0; read at 9'o101 or 9'o077 -> data_out 0.

Source files
------------

// File: rtl/simplez_pkg.sv
// Shared constants and types for the Simplez peripheral slice.
// Bus widths, peripheral addresses and the UART transmit FSM encoding.
package simplez_pkg;

  localparam int DATAW      = 12;
  localparam int ADDRW      = 9;
  localparam int BAUDW      = 10;
  localparam int FIFO_DEPTH = 4;

  localparam logic [ADDRW-1:0] ADDR_UART_DATA = 9'o101;
  localparam logic [ADDRW-1:0] ADDR_UART_STAT = 9'o102;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [DATAW-1:0] pack_status(input logic ovf, input logic busy,
                                                   input logic ready);
    return {{(DATAW-3){1'b0}}, ovf, busy, ready};
  endfunction

endpackage

// File: rtl/simplez_fifo.sv
// Four-entry byte FIFO clocked on the falling edge like the Simplez CPU.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module simplez_fifo
  import simplez_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [2:0] count_o
);

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic [2:0] count_q, count_d;
  logic       push_ok;
  logic       pop_ok;

  assign full_o  = (count_q == 3'd4);
  assign empty_o = (count_q == 3'd0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wptr_d  = wptr_q + 2'(push_ok);
    rptr_d  = rptr_q + 2'(pop_ok);
    count_d = count_q + 3'(push_ok) - 3'(pop_ok);
  end

  always_ff @(negedge clk) begin
    if (!rstn) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(negedge clk) begin
    if (rstn && push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/simplez_uart_tx.sv
// Simplez bus-mapped 8N1 UART transmitter with a 4-byte FIFO.
// Data register pushes bytes; status register reports {ovf, busy, ready}.
module simplez_uart_tx
  import simplez_pkg::*;
#(
  parameter int               BAUD_DIV  = 104,
  parameter logic [ADDRW-1:0] ADDR_DATA = ADDR_UART_DATA,
  parameter logic [ADDRW-1:0] ADDR_STAT = ADDR_UART_STAT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ADDRW-1:0] addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             tx
);

  localparam logic [BAUDW-1:0] BAUD_RELOAD = BAUDW'(BAUD_DIV - 1);

  tx_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [BAUDW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic             data_wr;
  logic             stat_rd;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [2:0]       fifo_count;
  logic [7:0]       fifo_head;
  logic             period_end;
  logic             drop;
  logic             busy;
  logic             ready;
  logic             unused_data_hi;

  assign data_wr        = wr && (addr == ADDR_DATA);
  assign stat_rd        = rd && (addr == ADDR_STAT);
  assign unused_data_hi = ^data_in[DATAW-1:8];

  simplez_fifo u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (data_wr),
    .pop_i   (fifo_pop),
    .wdata_i (data_in[7:0]),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A push is lost only when the FIFO is full and the FSM is not freeing a slot.
  assign drop = data_wr && fifo_full && !fifo_pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (stat_rd) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (!rstn) begin
      state_q <= TX_IDLE;
      shift_q <= 8'd0;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign period_end = (baud_q == '0);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          baud_d   = BAUD_RELOAD;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (period_end) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q - BAUDW'(1);
        end
      end
      TX_DATA: begin
        if (period_end) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUDW'(1);
        end
      end
      TX_STOP: begin
        // Chain straight into the next start bit so queued bytes leave no idle gap.
        if (period_end) begin
          baud_d = BAUD_RELOAD;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUDW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level is registered from the next state so tx changes exactly on the state edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      TX_IDLE:  tx_d = 1'b1;
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      TX_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    busy     = (state_q != TX_IDLE) || !fifo_empty;
    ready    = (fifo_count < 3'd4);
    data_out = stat_rd ? pack_status(ovf_q, busy, ready) : '0;
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_simplez_uart_tx.sv
// Self-checking bench for simplez_uart_tx with BAUD_DIV=4.
// Frame-level reference model plus table vectors and corner-case sequences.
module tb_simplez_uart_tx;

  localparam int BD = 4;
  localparam int FRAME = 10 * BD;
  localparam logic [8:0] A_DATA  = 9'o101;
  localparam logic [8:0] A_STAT  = 9'o102;
  localparam logic [8:0] A_OTHER = 9'o077;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr;
  logic        rd;
  logic [8:0]  addr;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic        tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simplez_uart_tx #(
    .BAUD_DIV  (BD),
    .ADDR_DATA (A_DATA),
    .ADDR_STAT (A_STAT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .addr     (addr),
    .wr       (wr),
    .rd       (rd),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx)
  );

  // Reference model: byte queue, position inside the current frame (-1 = idle), sticky ovf.
  logic [7:0] mq[$];
  int         m_pos = -1;
  logic [7:0] m_cur = 8'd0;
  logic       m_ovf = 1'b0;

  function automatic logic [11:0] m_status();
    logic busy_v, ready_v;
    busy_v  = (m_pos >= 0) || (mq.size() > 0);
    ready_v = (mq.size() < 4);
    return {9'b0, m_ovf, busy_v, ready_v};
  endfunction

  function automatic logic m_tx();
    int j;
    if (m_pos < 0) return 1'b1;
    j = m_pos / BD;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return m_cur[j-1];
  endfunction

  task automatic m_step(input logic r, input logic w, input logic rdv,
                        input logic [8:0] a, input logic [7:0] d);
    int pre;
    bit pop, drop;
    if (!r) begin
      mq.delete();
      m_pos = -1;
      m_ovf = 1'b0;
      m_cur = 8'd0;
      return;
    end
    pre  = mq.size();
    pop  = (pre > 0) && ((m_pos < 0) || (m_pos == FRAME - 1));
    drop = 1'b0;
    if (pop) begin
      m_cur = mq.pop_front();
      m_pos = 0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
    if (w && a == A_DATA) begin
      if (pre < 4 || pop) mq.push_back(d);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (rdv && a == A_STAT) m_ovf = 1'b0;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: data_out sampled before the falling edge, tx just after it.
  task automatic drive(input logic r, input logic w, input logic rdv, input logic [8:0] a,
                       input logic [11:0] d, output logic [11:0] o_dout, output logic o_tx);
    logic [11:0] exp_d;
    rstn = r; wr = w; rd = rdv; addr = a; data_in = d;
    #1;
    exp_d  = (rdv && a == A_STAT) ? m_status() : 12'h000;
    o_dout = data_out;
    check("dout_model", data_out, exp_d);
    @(negedge clk);
    m_step(r, w, rdv, a, d[7:0]);
    #1;
    o_tx = tx;
    check("tx_model", {11'b0, tx}, {11'b0, m_tx()});
  endtask

  logic [11:0] ob_d;
  logic        ob_t;

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, A_OTHER, 12'h000, ob_d, ob_t);
  endtask

  task automatic write_byte(input logic [7:0] b);
    drive(1'b1, 1'b1, 1'b0, A_DATA, {4'h0, b}, ob_d, ob_t);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_pos >= 0 || mq.size() > 0) && n < 1000) begin
      idle();
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
  endtask

  typedef struct {
    logic        rstn_v;
    logic        wr_v;
    logic        rd_v;
    logic [8:0]  addr_v;
    logic [11:0] din_v;
    logic [11:0] exp_dout;
    logic        exp_tx;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [9:0] fa, fb;
    logic [7:0] b0, b1;
    int n;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, A_STAT,  12'h000, 12'h001, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, A_OTHER, 12'h055, 12'h000, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, A_DATA,  12'h000, 12'h000, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, A_STAT,  12'h0AA, 12'h001, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, A_STAT,  12'h000, 12'h001, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, A_DATA,  12'hF55, 12'h000, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, A_STAT,  12'h000, 12'h003, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, A_OTHER, 12'h000, 12'h000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, A_OTHER, 12'h000, 12'h000, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, A_OTHER, 12'h000, 12'h000, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, A_STAT,  12'h000, 12'h003, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, A_OTHER, 12'h000, 12'h000, 1'b1};

    rstn = 1'b0; wr = 1'b0; rd = 1'b0; addr = A_OTHER; data_in = 12'h000;
    @(negedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, A_OTHER, 12'h000, ob_d, ob_t);
    drive(1'b0, 1'b0, 1'b0, A_OTHER, 12'h000, ob_d, ob_t);
    check("reset_tx", {11'b0, ob_t}, 12'h001);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rstn_v, tbl[i].wr_v, tbl[i].rd_v, tbl[i].addr_v, tbl[i].din_v, ob_d, ob_t);
      check($sformatf("vec%0d_dout", i), ob_d, tbl[i].exp_dout);
      check($sformatf("vec%0d_tx", i), {11'b0, ob_t}, {11'b0, tbl[i].exp_tx});
    end
    drain();

    // Single 0x55 frame: 4 low, alternating data LSB first, 4 high.
    fa = {1'b1, 8'h55, 1'b0};
    write_byte(8'h55);
    for (int k = 0; k < FRAME; k++) begin
      drive(1'b1, 1'b0, 1'b1, A_STAT, 12'h000, ob_d, ob_t);
      check("frame55_stat", ob_d, 12'h003);
      check($sformatf("frame55_tx%0d", k), {11'b0, ob_t}, {11'b0, fa[k/BD]});
    end
    idle();
    drive(1'b1, 1'b0, 1'b1, A_STAT, 12'h000, ob_d, ob_t);
    check("frame55_done_stat", ob_d, 12'h001);

    // Five writes fill the FIFO behind the active byte; the sixth is dropped.
    for (int i = 0; i < 5; i++) write_byte(8'h41 + 8'(i));
    drive(1'b1, 1'b0, 1'b1, A_STAT, 12'h000, ob_d, ob_t);
    check("full_noovf_stat", ob_d, 12'h002);
    write_byte(8'h46);
    drive(1'b1, 1'b0, 1'b1, A_STAT, 12'h000, ob_d, ob_t);
    check("ovf_stat", ob_d, 12'h006);
    drive(1'b1, 1'b0, 1'b1, A_STAT, 12'h000, ob_d, ob_t);
    check("ovf_cleared_stat", ob_d, 12'h002);
    drain();

    // Two queued bytes: second start bit follows first stop bit directly.
    b0 = 8'h3C; b1 = 8'hA5;
    fa = {1'b1, b0, 1'b0};
    fb = {1'b1, b1, 1'b0};
    write_byte(b0);
    write_byte(b1);
    check("b2b_tx0", {11'b0, ob_t}, 12'h000);
    for (int k = 1; k < 2 * FRAME; k++) begin
      idle();
      if (k < FRAME) check($sformatf("b2b_tx%0d", k), {11'b0, ob_t}, {11'b0, fa[k/BD]});
      else check($sformatf("b2b_tx%0d", k), {11'b0, ob_t}, {11'b0, fb[(k-FRAME)/BD]});
    end
    idle();
    check("b2b_end_tx", {11'b0, ob_t}, 12'h001);
    drive(1'b1, 1'b0, 1'b1, A_STAT, 12'h000, ob_d, ob_t);
    check("b2b_end_stat", ob_d, 12'h001);

    // Reset 15 cycles into a frame with a second byte still queued.
    write_byte(8'h00);
    write_byte(8'h81);
    for (int k = 1; k < 15; k++) idle();
    drive(1'b0, 1'b0, 1'b1, A_STAT, 12'h000, ob_d, ob_t);
    check("midrst_pre_stat", ob_d, 12'h003);
    check("midrst_tx", {11'b0, ob_t}, 12'h001);
    drive(1'b1, 1'b0, 1'b1, A_STAT, 12'h000, ob_d, ob_t);
    check("midrst_stat", ob_d, 12'h001);
    for (int k = 0; k < 50; k++) begin
      idle();
      check("midrst_quiet_tx", {11'b0, ob_t}, 12'h001);
    end

    // Full FIFO with a push on the stop-end pop edge is accepted without ovf.
    for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i));
    n = 0;
    while (m_pos != FRAME - 1 && n < 200) begin
      idle();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_stop_end: got timeout expected stop end");
    end
    write_byte(8'h99);
    drive(1'b1, 1'b0, 1'b1, A_STAT, 12'h000, ob_d, ob_t);
    check("popedge_push_stat", ob_d, 12'h002);
    drive(1'b1, 1'b0, 1'b1, A_DATA, 12'h000, ob_d, ob_t);
    check("rd_data_addr", ob_d, 12'h000);
    drive(1'b1, 1'b0, 1'b1, A_OTHER, 12'h000, ob_d, ob_t);
    check("rd_other_addr", ob_d, 12'h000);
    drain();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic        r, w, rv;
      logic [8:0]  a;
      int          sel;
      r   = ($urandom_range(0, 299) != 0);
      w   = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 5);
      if (sel < 3) a = A_DATA;
      else if (sel < 5) a = A_STAT;
      else a = 9'($urandom_range(0, 511));
      drive(r, w, rv, a, 12'($urandom_range(0, 4095)), ob_d, ob_t);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
